// File: rtl/tessia_mem_subsystem.sv
// Data-memory subsystem for the Tessia core: valid/ready request port, configurable read
// latency, byte-enabled writes, address-fault reporting, GPIO and cycle-counter registers.
module tessia_mem_subsystem #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 256,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   gpio_out,
    output logic [1:0]          dbg_state
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // WAIT lasts RD_LAT-1 cycles; the counter is loaded with the number of extra cycles.
    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE out of reset, and rsp_valid is a single-cycle strobe
    // with no backpressure.

    logic [1:0]        state;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] gpio_q;
    logic [DATA_W-1:0] cycle_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic          accept;
    logic          misaligned;
    logic          hit_gpio;
    logic          hit_cnt;
    logic          hit_mem;
    logic          is_err;
    logic [AW-1:0] idx;

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign hit_gpio   = !misaligned && (req_addr == MMIO_BASE);
    assign hit_cnt    = !misaligned && (req_addr == MMIO_BASE + 32'd4);
    assign hit_mem    = !misaligned && !hit_gpio && !hit_cnt && (req_addr[31:AW+2] == '0);
    assign is_err     = !(hit_gpio || hit_cnt || hit_mem);
    assign idx        = req_addr[AW+1:2];

    // Storage is deliberately not reset; a write lands on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && hit_mem) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            gpio_q   <= '0;
            cycle_q  <= '0;
        end else begin
            cycle_q <= cycle_q + DATA_W'(1);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        err_q    <= is_err;
                        wait_cnt <= WAIT_INIT;
                        rdata_q  <= '0;
                        // Read data is captured on the accept edge and held until RESP.
                        if (!req_we && !is_err) begin
                            if (hit_gpio) begin
                                rdata_q <= gpio_q;
                            end else if (hit_cnt) begin
                                rdata_q <= cycle_q;
                            end else begin
                                rdata_q <= mem[idx];
                            end
                        end
                        if (req_we && hit_gpio) begin
                            for (int i = 0; i < NB; i++) begin
                                if (req_be[i]) begin
                                    gpio_q[8*i +: 8] <= req_wdata[8*i +: 8];
                                end
                            end
                        end
                        if (req_we || is_err || (RD_LAT == 1)) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = reset && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;
    assign gpio_out  = gpio_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_tessia_mem_subsystem.sv
// Bench for tessia_mem_subsystem: directed plan steps plus random traffic against a
// behavioural memory/register model, and a read-latency sweep on extra instances.
module tb_tessia_mem_subsystem;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] gpio_out;
    logic [1:0]  dbg_state;

    logic        sw_valid     [3];
    logic        sw_ready     [3];
    logic        sw_rsp_valid [3];
    logic [31:0] sw_rdata     [3];
    logic        sw_err       [3];
    logic [31:0] sw_gpio      [3];
    logic [1:0]  sw_dbg       [3];
    logic        sw_we;
    logic [31:0] sw_addr;
    logic [31:0] sw_wdata;
    logic [3:0]  sw_be;

    int          tot = 0;
    int          bad = 0;
    logic [31:0] cyc_m;
    logic [31:0] last_acc;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] gpio_m;
    logic [31:0] exp_q[$];

    tessia_mem_subsystem #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(LAT), .MMIO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .gpio_out(gpio_out), .dbg_state(dbg_state)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        tessia_mem_subsystem #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT((g == 0) ? 1 : g + 2),
                               .MMIO_BASE(BASE)) u_sw (
            .clk(clk), .reset(reset), .req_valid(sw_valid[g]), .req_ready(sw_ready[g]),
            .req_we(sw_we), .req_addr(sw_addr), .req_wdata(sw_wdata), .req_be(sw_be),
            .rsp_valid(sw_rsp_valid[g]), .rsp_rdata(sw_rdata[g]), .rsp_err(sw_err[g]),
            .gpio_out(sw_gpio[g]), .dbg_state(sw_dbg[g])
        );
    end

    // Clock and reset-relative cycle count (cycles elapsed since reset release).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc_m <= 32'd0;
        else        cyc_m <= cyc_m + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Reference behaviour of one accepted request, evaluated just before its accept edge.
    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output logic err,
                           output int lat);
        rd       = 32'd0;
        err      = 1'b0;
        lat      = we ? 1 : LAT;
        last_acc = cyc_m;
        if (addr % 4 != 0) begin
            err = 1'b1;
            lat = 1;
        end else if (addr == BASE) begin
            if (we) gpio_m = apply_be(gpio_m, wd, be);
            else    rd = gpio_m;
        end else if (addr == BASE + 32'd4) begin
            if (!we) rd = cyc_m;
        end else if (addr / 4 < DEPTH) begin
            if (we) mem_m[addr / 4] = apply_be(mem_m[addr / 4], wd, be);
            else    rd = mem_m[addr / 4];
        end else begin
            err = 1'b1;
            lat = 1;
        end
    endtask

    // Driver: present a request, wait for accept, then time and check the response.
    // Called and returns #1 after a rising edge.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, output logic [31:0] got);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready_for_accept"}, 32'(req_ready), 32'd1);
        predict(we, addr, wd, be, e_rd, e_err, e_lat);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check({tag, " gpio_out"}, gpio_out, gpio_m);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 8) begin
            check({tag, " busy_ready"}, 32'(req_ready), 32'd0);
            check({tag, " idle_rdata"}, rsp_rdata, 32'd0);
            check({tag, " idle_err"}, 32'(rsp_err), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(e_lat));
        check({tag, " rsp_ready"}, 32'(req_ready), 32'd0);
        check({tag, " err"}, 32'(rsp_err), 32'(e_err));
        check({tag, " rdata"}, rsp_rdata, e_rd);
        got = rsp_rdata;
        @(posedge clk); #1;
        check({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] r1;
        logic [31:0] a1;
        logic [31:0] waddr;
        int          sel;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        sw_we     = 1'b0;
        sw_addr   = BASE + 32'd4;
        sw_wdata  = 32'd0;
        sw_be     = 4'd0;
        for (int g = 0; g < 3; g++) sw_valid[g] = 1'b0;
        gpio_m = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        check("rst gpio", gpio_out, 32'd0);
        check("rst sw_gpio", sw_gpio[0], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst ready", 32'(req_ready), 32'd1);
        check("post_rst rsp_valid", 32'(rsp_valid), 32'd0);

        // Basic write then read back
        do_req("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
        do_req("rd10", 1'b0, 32'h10, 32'h0, 4'h0, got);
        check("rd10 const", got, 32'hDEADBEEF);

        // Partial byte-enable write
        do_req("wr20", 1'b1, 32'h20, 32'h11223344, 4'hF, got);
        do_req("wr20p", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, got);
        do_req("rd20", 1'b0, 32'h20, 32'h0, 4'h0, got);
        check("rd20 const", got, 32'h11BB33DD);
        do_req("wr20z", 1'b1, 32'h20, 32'h0, 4'h0, got);
        do_req("rd20z", 1'b0, 32'h20, 32'h0, 4'h0, got);

        // Address faults leave storage untouched
        do_req("wr0", 1'b1, 32'h0, 32'hCAFE0001, 4'hF, got);
        do_req("rd_mis", 1'b0, 32'h3, 32'h0, 4'h0, got);
        do_req("rd_oor", 1'b0, 32'h400, 32'h0, 4'h0, got);
        do_req("wr_mis", 1'b1, 32'h1, 32'h12345678, 4'hF, got);
        do_req("wr_oor", 1'b1, 32'h400, 32'h12345678, 4'hF, got);
        do_req("rd0", 1'b0, 32'h0, 32'h0, 4'h0, got);
        check("rd0 const", got, 32'hCAFE0001);

        // GPIO and counter registers
        do_req("gpio_wr", 1'b1, BASE, 32'h5, 4'hF, got);
        check("gpio const", gpio_out, 32'h5);
        do_req("gpio_rd", 1'b0, BASE, 32'h0, 4'h0, got);
        do_req("cnt_wr", 1'b1, BASE + 32'd4, 32'hFFFF_FFFF, 4'hF, got);
        do_req("cnt_rd1", 1'b0, BASE + 32'd4, 32'h0, 4'h0, r1);
        a1 = last_acc;
        repeat (7) @(posedge clk);
        #1;
        do_req("cnt_rd2", 1'b0, BASE + 32'd4, 32'h0, 4'h0, got);
        check("cnt delta", got - r1, last_acc - a1);

        // Random traffic over a preloaded window of storage plus the registers
        for (int w = 0; w < 16; w++) do_req("init", 1'b1, 32'(w * 4), $urandom, 4'hF, got);
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       waddr = BASE;
                7:       waddr = BASE + 32'd4;
                8:       waddr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                9:       waddr = 32'h400 + 32'($urandom_range(0, 1000) * 4);
                default: waddr = 32'($urandom_range(0, 15) * 4);
            endcase
            do_req("rand", 1'($urandom), waddr, $urandom, 4'($urandom), got);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of a read's WAIT
        do_req("gpio_wr2", 1'b1, BASE, 32'hA5A5_0003, 4'hF, got);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("midrst ready", 32'(req_ready), 32'd0);
            check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
            check("midrst gpio", gpio_out, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset  = 1'b1;
        gpio_m = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("postrst no_rsp", 32'(rsp_valid), 32'd0);
            check("postrst ready", 32'(req_ready), 32'd1);
        end
        do_req("postrst rd10", 1'b0, 32'h10, 32'h0, 4'h0, got);
        do_req("postrst gpio", 1'b0, BASE, 32'h0, 4'h0, got);
        do_req("postrst cnt", 1'b0, BASE + 32'd4, 32'h0, 4'h0, got);

        // Back-to-back counter reads with req_valid held, RD_LAT = 1, 3, 4
        for (int g = 0; g < 3; g++) begin
            int lat;
            int last;
            int n_acc;
            int n_rsp;
            lat   = (g == 0) ? 1 : g + 2;
            last  = -1;
            n_acc = 0;
            n_rsp = 0;
            exp_q.delete();
            @(negedge clk);
            sw_valid[g] = 1'b1;
            for (int c = 0; c < 48; c++) begin
                if (sw_rsp_valid[g]) begin
                    n_rsp++;
                    check("sw rsp_has_req", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("sw rdata", sw_rdata[g], exp_q.pop_front());
                    check("sw err", 32'(sw_err[g]), 32'd0);
                end
                if (c == 40) sw_valid[g] = 1'b0;
                if (sw_valid[g] && sw_ready[g]) begin
                    if (last >= 0) check("sw interval", 32'(c - last), 32'(lat + 1));
                    last = c;
                    n_acc++;
                    exp_q.push_back(cyc_m);
                end
                @(negedge clk);
            end
            check("sw accepts", 32'(n_acc), 32'(39 / (lat + 1) + 1));
            check("sw rsp_count", 32'(n_rsp), 32'(n_acc));
            check("sw drained", 32'(exp_q.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #400000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/tessia_mem_subsystem.md
# tessia_mem_subsystem

Parametrised data-memory subsystem for the Tessia core that replaces the fixed single-cycle data memory. It provides a valid/ready request port, a configurable read latency, byte-enabled writes and error reporting for bad addresses. It also maps two I/O registers: a GPIO output register and a free-running cycle counter. It sits between the core's load/store path and the word-addressed storage array, one outstanding transaction at a time.

## Interface
- DATA_W, 32: data width in bits (multiple of 8)
- DEPTH, 256: storage words (power of 2)
- RD_LAT, 2: read latency in cycles, legal 1..4
- MMIO_BASE, 32'hFFFF_0000: byte address of GPIO; counter at MMIO_BASE+4
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  subsystem can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes, ignored on reads
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  qualifies rsp_valid: address fault
- gpio_out  out  DATA_W  GPIO register contents

## Operation
- FSM states:
  - IDLE: req_ready=1. On accept (req_valid && req_ready), write → RESP; read with RD_LAT=1 → RESP; read with RD_LAT>1 → WAIT.
  - WAIT: counts RD_LAT-1 cycles, then → RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then → IDLE.
- Request fields are sampled only on the accept edge and are held internally. Inputs may change freely afterward.
- Address decode, in priority order:
  - Misaligned (addr[1:0]≠0): error.
  - addr==MMIO_BASE: GPIO, read/write.
  - addr==MMIO_BASE+4: counter; reads return the count, writes are ignored without error.
  - Word index addr[31:2] < DEPTH: storage.
  - Anything else: error.
- Writes:
  - Storage and GPIO are updated on the accept edge.
  - Only bytes with req_be[i]=1 change.
  - req_be=0 is a legal no-op that still gets a response.
- Errors:
  - No state changes.
  - Response is issued after 1 cycle for both reads and writes; RD_LAT does not apply.
  - rsp_err=1, rsp_rdata=0.
- Reads return the storage/GPIO value as of the accept edge.
- Cycle counter:
  - Increments every cycle from reset, including while busy.
  - Wraps from 2^DATA_W−1 to 0.
  - A read returns the value at the accept edge.
- There is no response backpressure. The consumer must take rsp_valid when it is asserted.

## Timing
- Reset asserted (any time, asynchronously):
  - State → IDLE.
  - req_ready=0 while reset is low, 1 from the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, counter=0.
  - Storage contents are not reset.
- Reset mid-transaction: the pending transaction is dropped with no response. A storage write already performed on its accept edge remains.
- Accept at edge T:
  - req_ready falls after T and stays low until RESP is left.
  - Write or error: rsp_valid high in cycle T+1; req_ready high again in cycle T+2.
  - Valid read: rsp_valid high in cycle T+RD_LAT; req_ready high again in cycle T+RD_LAT+1.
- Throughput: one write per 2 cycles; one read per RD_LAT+1 cycles.
- req_valid asserted while req_ready=0 is not accepted and has no effect. The master holds the request until it is accepted.
- rsp_rdata and rsp_err are valid only while rsp_valid=1, and are 0 otherwise.

## Test plan
- Reset then write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 with RD_LAT=2 → write ack at T+1 (err=0); read rsp_valid at T+2 with rdata=32'hDEADBEEF; req_ready low in T+1..T+2.
- Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with be=4'b0101, then read 0x20 → rdata=32'h11BB33DD.
- Read 0x3 (misaligned) and read 0x400 with DEPTH=256 → each gives rsp_valid at T+1 with err=1, rdata=0; a later read of word 0 shows the storage unchanged.
- Write 32'h5 to MMIO_BASE → gpio_out=5 from cycle T+1. Write to MMIO_BASE+4 → err=0 and the counter keeps counting. Two counter reads accepted N cycles apart → the returned values differ by N.
- Assert reset during the WAIT of a read → no rsp_valid; gpio_out=0 and req_ready=0 while reset is low; req_ready=1 after release; data written before reset is still readable.
- Hold req_valid=1 continuously with back-to-back reads, sweeping RD_LAT over 1,3,4 → exactly one accept per RD_LAT+1 cycles and one rsp_valid per request, in order.
